// File: rtl/spi_three_wire.sv
// Control FSM for a 3-wire SPI master: sequences load/shift/done and gates SPC.
// Optional BUSY output is enabled by defining SPI_THREE_WIRE_BUSY_EN.
module spi_three_wire #(
    parameter int CNT_W    = 4,
    parameter int LAST_BIT = 15
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             GO,
    input  logic [CNT_W-1:0] bitcount,
    output logic             SCLK,
    output logic             bitcountEN,
    output logic             rstbitcount,
    output logic             LDEN,
    output logic             SHEN,
    output logic             SCEN,
    output logic             ORDY,
`ifdef SPI_THREE_WIRE_BUSY_EN
    output logic             BUSY,
`endif
    output logic             SPC
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic rstbitcount;
        logic bitcounten;
        logic lden;
        logic shen;
        logic scen;
        logic ordy;
`ifdef SPI_THREE_WIRE_BUSY_EN
        logic busy;
`endif
    } ctrl_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BIT);

    state_t state;
    ctrl_t  ctrl;

    // Moore decode of the state being entered, so outputs come straight from flops.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c             = '0;
        c.rstbitcount = (s == IDLE) || (s == LOAD);
        c.lden        = (s == LOAD);
        c.shen        = (s == SHIFT);
        c.scen        = (s == SHIFT);
        c.bitcounten  = (s == SHIFT);
        c.ordy        = (s == DONE);
`ifdef SPI_THREE_WIRE_BUSY_EN
        c.busy        = (s != IDLE);
`endif
        return c;
    endfunction

    // NOTE: state and output flops use non-blocking assignments so every
    // register samples the pre-edge values; blocking here would create races.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            ctrl  <= decode(IDLE);
        end else begin
            unique case (state)
                IDLE: begin
                    if (GO) begin
                        state <= LOAD;
                        ctrl  <= decode(LOAD);
                    end else begin
                        state <= IDLE;
                        ctrl  <= decode(IDLE);
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                    ctrl  <= decode(SHIFT);
                end
                SHIFT: begin
                    if (bitcount == LAST_CNT) begin
                        state <= DONE;
                        ctrl  <= decode(DONE);
                    end else begin
                        state <= SHIFT;
                        ctrl  <= decode(SHIFT);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ctrl  <= decode(IDLE);
                end
                default: begin
                    state <= IDLE;
                    ctrl  <= decode(IDLE);
                end
            endcase
        end
    end

    assign rstbitcount = ctrl.rstbitcount;
    assign bitcountEN  = ctrl.bitcounten;
    assign LDEN        = ctrl.lden;
    assign SHEN        = ctrl.shen;
    assign SCEN        = ctrl.scen;
    assign ORDY        = ctrl.ordy;
`ifdef SPI_THREE_WIRE_BUSY_EN
    assign BUSY        = ctrl.busy;
`endif

    // SCEN only moves on the rising edge while CLK is high, so the gate cannot glitch SPC low.
    assign SCLK = CLK;
    assign SPC  = SCEN ? SCLK : 1'b1;

endmodule

// File: tb/tb_spi_three_wire.sv
// Scoreboard bench for spi_three_wire: transfer-level model feeds an expectation queue.
// Define SPI_THREE_WIRE_BUSY_EN to also check the BUSY output.
module tb_spi_three_wire;

    localparam int CNT_W    = 4;
    localparam int LAST_BIT = 15;

    logic             CLK = 1'b0;
    logic             reset;
    logic             GO;
    logic [CNT_W-1:0] bitcount;
    logic             SCLK, bitcountEN, rstbitcount, LDEN, SHEN, SCEN, ORDY, SPC;
`ifdef SPI_THREE_WIRE_BUSY_EN
    logic             BUSY;
`endif

    spi_three_wire #(.CNT_W(CNT_W), .LAST_BIT(LAST_BIT)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .GO          (GO),
        .bitcount    (bitcount),
        .SCLK        (SCLK),
        .bitcountEN  (bitcountEN),
        .rstbitcount (rstbitcount),
        .LDEN        (LDEN),
        .SHEN        (SHEN),
        .SCEN        (SCEN),
        .ORDY        (ORDY),
`ifdef SPI_THREE_WIRE_BUSY_EN
        .BUSY        (BUSY),
`endif
        .SPC         (SPC)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic rstb;
        logic bcen;
        logic lden;
        logic shen;
        logic scen;
        logic ordy;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   failures     = 0;
    int   exp_done_cnt = 0;
    int   obs_ordy_cnt = 0;

    // Transfer model: where the controller is in the frame, named by phase.
    string phase = "unknown";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t outputs_for(input string ph);
        exp_t e;
        e      = '0;
        e.busy = (ph != "idle");
        if (ph == "idle") e.rstb = 1'b1;
        if (ph == "load") begin e.lden = 1'b1; e.rstb = 1'b1; end
        if (ph == "shift") begin e.shen = 1'b1; e.scen = 1'b1; e.bcen = 1'b1; end
        if (ph == "done") e.ordy = 1'b1;
        return e;
    endfunction

    // One clock of stimulus: apply inputs, advance the model, queue what the DUT must show next.
    task automatic step(input logic r, input logic g, input logic [CNT_W-1:0] bc);
        reset    = r;
        GO       = g;
        bitcount = bc;
        if (r)                                         phase = "idle";
        else if (phase == "idle")                      phase = g ? "load" : "idle";
        else if (phase == "load")                      phase = "shift";
        else if (phase == "shift")                     phase = (int'(bc) == LAST_BIT) ? "done" : "shift";
        else if (phase == "done")                      phase = "idle";
        if (phase == "done") exp_done_cnt++;
        exp_q.push_back(outputs_for(phase));
        @(posedge CLK);
        @(negedge CLK);
    endtask

    exp_t cur;
    logic cur_valid = 1'b0;

    // Monitor: high half-cycle after each edge, pop and compare.
    initial begin
        exp_t e, act;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '0;
                act.rstb = rstbitcount;
                act.bcen = bitcountEN;
                act.lden = LDEN;
                act.shen = SHEN;
                act.scen = SCEN;
                act.ordy = ORDY;
`ifdef SPI_THREE_WIRE_BUSY_EN
                act.busy = BUSY;
`else
                e.busy   = 1'b0;
`endif
                check("ctrl_outputs", 32'(act), 32'(e));
                check("spc_clk_high", 32'(SPC), 32'd1);
                check("sclk_high", 32'(SCLK), 32'd1);
                if (ORDY === 1'b1) obs_ordy_cnt++;
                cur       = e;
                cur_valid = 1'b1;
            end
        end
    end

    // Low half-cycle: SPC must follow CLK low only while shifting.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (cur_valid) begin
                check("spc_clk_low", 32'(SPC), cur.scen ? 32'd0 : 32'd1);
                check("sclk_low", 32'(SCLK), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        GO       = 1'b0;
        bitcount = '0;

        // Reset hold.
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);

        // Start, full count sweep with a GO pulse mid-shift, completion.
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < LAST_BIT; i++) step(1'b0, (i == 5), CNT_W'(i));
        step(1'b0, 1'b0, CNT_W'(LAST_BIT));
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);

        // Reset mid-transfer, even with bitcount at the last value.
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd3);
        step(1'b1, 1'b0, CNT_W'(LAST_BIT));
        step(1'b0, 1'b0, 4'd0);

        // Back-to-back with GO held high throughout.
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < LAST_BIT; i++) step(1'b0, 1'b1, CNT_W'(i));
        step(1'b0, 1'b1, CNT_W'(LAST_BIT));
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, CNT_W'(LAST_BIT));
        step(1'b0, 1'b0, 4'd0);

        // Randomized traffic, biased towards frame completion.
        for (int n = 0; n < 3000; n++) begin
            logic             r, g;
            logic [CNT_W-1:0] bc;
            r  = ($urandom_range(0, 99) == 0);
            g  = ($urandom_range(0, 5) == 0);
            bc = ($urandom_range(0, 3) == 0) ? CNT_W'(LAST_BIT) : CNT_W'($urandom_range(0, 15));
            step(r, g, bc);
        end

        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("ordy_pulse_count", 32'(obs_ordy_cnt), 32'(exp_done_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_three_wire.md
Name: spi_three_wire

Overview:
- Control FSM for a 3-wire SPI master.
- On a GO pulse it sequences load, shift and done phases, drives the enables for an external shift register and bit counter, and gates the serial clock SPC onto the bus only while shifting.
- The bit counter sits outside the block and is fed back on `bitcount`. ORDY flags transfer completion to the host logic.

Parameters:
- CNT_W, 4, width of the `bitcount` input.
- LAST_BIT, 15, `bitcount` value that ends the SHIFT phase (16-bit frame).

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- GO  input  1  start request, sampled on the rising edge of CLK.
- bitcount  input  CNT_W  current value of the external bit counter.
- SCLK  output  1  serial clock source; combinational copy of CLK.
- bitcountEN  output  1  increment enable for the external bit counter.
- rstbitcount  output  1  synchronous clear for the external bit counter.
- LDEN  output  1  parallel-load enable for the external shift register.
- SHEN  output  1  shift enable for the external shift register.
- SCEN  output  1  serial clock enable.
- ORDY  output  1  output-ready / transfer-complete strobe.
- SPC  output  1  SPI bus clock: SCLK when SCEN=1, otherwise 1 (idle high).

Behaviour:
- One clock; reset is synchronous and active-high.
- States, 2-bit register: IDLE, LOAD, SHIFT, DONE.
- Transitions:
  - reset=1 → IDLE on the next edge, overriding everything, including mid-transfer.
  - IDLE: GO=1 → LOAD; else stay in IDLE.
  - LOAD → SHIFT unconditionally (exactly 1 cycle).
  - SHIFT: bitcount==LAST_BIT → DONE; else stay in SHIFT.
  - DONE → IDLE unconditionally (exactly 1 cycle).
- Outputs are Moore-decoded from state (no input paths), except SPC/SCLK:
  - IDLE: rstbitcount=1; all other enables 0.
  - LOAD: LDEN=1, rstbitcount=1; others 0.
  - SHIFT: SHEN=1, SCEN=1, bitcountEN=1; others 0.
  - DONE: ORDY=1; others 0.
- SCLK = CLK (combinational). SPC = SCEN ? SCLK : 1'b1, glitch-free because SCEN changes only on the rising edge of CLK.
- Reset values: state=IDLE, so rstbitcount=1, bitcountEN=LDEN=SHEN=SCEN=ORDY=0, SPC=1.
- GO held high or re-asserted during LOAD/SHIFT/DONE is ignored.
- GO still high when DONE → IDLE starts a new transfer one cycle later (IDLE→LOAD on the following edge).
- Latency:
  - GO sampled at edge N → LDEN high during cycle N..N+1.
  - SHIFT entered at edge N+1.
  - DONE entered on the first edge at which bitcount==LAST_BIT in SHIFT.
  - ORDY high for exactly one cycle.
- bitcount values other than LAST_BIT, including wrap-around, never leave SHIFT.
- bitcount is ignored in all states except SHIFT.

Optional Feature:
- Macro SPI_THREE_WIRE_BUSY_EN.
- Defined: adds output port BUSY (1 bit).
  - BUSY=1 in LOAD, SHIFT and DONE; 0 in IDLE.
  - BUSY=0 while reset is asserted and after reset.
- Undefined: no BUSY port; all other behaviour identical.

Test Plan:
- Reset hold: reset=1 for 2 edges with GO=0 → rstbitcount=1, SPC=1, all other enables 0.
- Start: deassert reset, GO=1 for one edge → next cycle LDEN=1 and rstbitcount=1, then SHEN=SCEN=bitcountEN=1, with SPC toggling in phase with CLK.
- Count sweep: in SHIFT, step bitcount 0..14 one per cycle → remains in SHIFT. bitcount=15 → DONE next cycle, ORDY=1 for exactly 1 cycle, then IDLE with SPC=1 and rstbitcount=1.
- GO ignored mid-shift: pulse GO while in SHIFT with bitcount=5 → no LDEN pulse, state unchanged.
- Reset mid-transfer: assert reset while in SHIFT → next edge IDLE, SCEN=0, SPC=1, ORDY never asserted.
- Back-to-back: GO held high through DONE → IDLE for 1 cycle, then LDEN=1. With SPI_THREE_WIRE_BUSY_EN defined, BUSY=1 for LOAD through DONE and 0 in that IDLE cycle.
